// File: rtl/cpu_debug_monitor_pkg.sv
// Shared defines for the CPU debug monitor: state encodings, default limits, bus widths.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.

`ifndef TEST_I_ADDR_WIDTH
`define TEST_I_ADDR_WIDTH 16
`endif

`ifndef STAGE_COUNT
`define STAGE_COUNT 5
`endif

package cpu_debug_monitor_pkg;

  localparam int DEF_HALT_COUNT     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  localparam int DEF_TRACE_DEPTH    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_t;

  // A verdict is final once one of these states is reached; only reset leaves them.
  function automatic logic is_terminal(mon_state_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO; pointers carry an extra wrap bit to tell full from empty.
// Latency: push visible at dout next cycle when empty; dout is the head read combinationally.
// Backpressure: push while full is accepted only with a simultaneous pop; pop while empty is ignored.

`ifdef CPU_MONITOR_TRACE_EN
module trace_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO by realigning the pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers mark them stale.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule
`endif

// File: rtl/cpu_debug_monitor.sv
// Watches a CPU's PC/stage vector and reaches a PASS/FAIL/TIMEOUT verdict; optional PC trace FIFO.
// Latency: verdict outputs are registered and appear together with the state they reflect.
// Backpressure: none on the CPU side; trace pushes drop (trace_ovf) when the FIFO is full.
// Optional feature macro: CPU_MONITOR_TRACE_EN (trace FIFO compiled in when defined).

module cpu_debug_monitor
  import cpu_debug_monitor_pkg::*;
#(
  parameter int ADDR_W         = `TEST_I_ADDR_WIDTH,
  parameter int STAGES         = `STAGE_COUNT,
  parameter int HALT_COUNT     = DEF_HALT_COUNT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TRACE_DEPTH    = DEF_TRACE_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] debug_program_counter,
  input  logic [STAGES-1:0] debug_pipeline_stage,
  input  logic              result,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       retired,
  input  logic              trace_rd,
  output logic [ADDR_W-1:0] trace_data,
  output logic              trace_empty,
  output logic              trace_ovf
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int HC_W = $clog2(HALT_COUNT) + 1;

  mon_state_t        state;
  mon_state_t        state_next;
  logic [WD_W-1:0]   wdog;
  logic [HC_W-1:0]   same_cnt;
  logic [HC_W-1:0]   same_cnt_next;
  logic [ADDR_W-1:0] last_pc;
  logic              in_run;
  logic              stage_bad;
  logic              retire;
  logic              halt;
  logic              wdog_expired;

  // A corrupted stage vector suppresses the retirement it might otherwise signal.
  assign in_run        = (state == ST_RUN);
  assign stage_bad     = !$onehot0(debug_pipeline_stage);
  assign retire        = in_run && !stage_bad && debug_pipeline_stage[STAGES-1];
  // same_cnt==0 means no retirement seen yet, so the first one always starts a run of 1.
  assign same_cnt_next = ((same_cnt != '0) && (debug_program_counter == last_pc))
                         ? same_cnt + 1'b1 : HC_W'(1);
  assign halt          = retire && (same_cnt_next == HC_W'(HALT_COUNT));
  assign wdog_expired  = (wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // Next-state: bad stage beats halt, halt beats watchdog; terminal states hold.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = ST_RUN;
      ST_RUN: begin
        if (stage_bad)         state_next = ST_FAIL;
        else if (halt)         state_next = result ? ST_PASS : ST_FAIL;
        else if (wdog_expired) state_next = ST_TIMEOUT;
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: state_next = state;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and verdict outputs decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      done    <= 1'b0;
      pass    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_next;
      done    <= is_terminal(state_next);
      pass    <= (state_next == ST_PASS);
      timeout <= (state_next == ST_TIMEOUT);
    end
  end

  // Watchdog, saturating retirement counter and same-PC run tracking, all active only in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog     <= '0;
      retired  <= '0;
      same_cnt <= '0;
      last_pc  <= '0;
    end else begin
      if (in_run) wdog <= wdog + 1'b1;
      if (retire) begin
        if (retired != 16'hFFFF) retired <= retired + 16'd1;
        same_cnt <= same_cnt_next;
        last_pc  <= debug_program_counter;
      end
    end
  end

`ifdef CPU_MONITOR_TRACE_EN
  logic fifo_full;

  trace_fifo #(
    .WIDTH(ADDR_W),
    .DEPTH(TRACE_DEPTH)
  ) u_trace_fifo (
    .clk  (clk),
    .reset(reset),
    .push (retire),
    .pop  (trace_rd),
    .din  (debug_program_counter),
    .dout (trace_data),
    .full (fifo_full),
    .empty(trace_empty)
  );

  // Sticky drop flag; a same-cycle pop frees the slot so nothing is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 trace_ovf <= 1'b0;
    else if (retire && fifo_full && !trace_rd)  trace_ovf <= 1'b1;
  end
`else
  logic [32:0] unused_trace;

  assign unused_trace = {trace_rd, 32'(TRACE_DEPTH)};
  assign trace_data   = '0;
  assign trace_empty  = 1'b1;
  assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_debug_monitor.sv
// Self-checking bench for cpu_debug_monitor against a history-based reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises FIFO overflow, pop-while-full and pops in terminal states.

module tb_cpu_debug_monitor;

  localparam int AW = 16;
  localparam int ST = 5;
  localparam int HC = 4;
  localparam int TC = 64;
  localparam int TD = 16;
  localparam logic [ST-1:0] RET = 5'b10000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc = '0;
  logic [ST-1:0] stage = '0;
  logic          result = 1'b0;
  logic          trace_rd = 1'b0;
  logic          done, pass, timeout, trace_empty, trace_ovf;
  logic [15:0]   retired;
  logic [AW-1:0] trace_data;

  int checks = 0;
  int failures = 0;

  // Reference model: verdict flags, RUN-cycle count and the list of retired PCs.
  bit            m_started, m_final, m_pass, m_tmo, m_ovf;
  int            m_runcyc, m_retired;
  int            m_hist[$];
  logic [AW-1:0] m_fifo[$];

  cpu_debug_monitor #(
    .ADDR_W(AW), .STAGES(ST), .HALT_COUNT(HC), .TIMEOUT_CYCLES(TC), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .reset(reset), .debug_program_counter(pc), .debug_pipeline_stage(stage),
    .result(result), .done(done), .pass(pass), .timeout(timeout), .retired(retired),
    .trace_rd(trace_rd), .trace_data(trace_data), .trace_empty(trace_empty), .trace_ovf(trace_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL tb_watchdog simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_started = 0; m_final = 0; m_pass = 0; m_tmo = 0; m_ovf = 0;
    m_runcyc = 0; m_retired = 0;
    m_hist.delete();
    m_fifo.delete();
  endtask

  // Predict the effect of one clock edge with the given inputs.
  task automatic model_edge(input logic [AW-1:0] p, input logic [ST-1:0] s,
                            input logic r, input logic rd);
    bit ret;
    bit was_full, was_empty;
    int trail;
    ret = 0;
    trail = 0;
    if (!m_started) begin
      m_started = 1;
    end else if (!m_final) begin
      m_runcyc++;
      if (s != 0 && (s & (s - 1)) != 0) begin
        m_final = 1;
      end else begin
        ret = s[ST-1];
        if (ret) begin
          trail = 1;
          for (int i = m_hist.size() - 1; i >= 0 && m_hist[i] == int'(p); i--) trail++;
          m_hist.push_back(int'(p));
          if (m_retired < 65535) m_retired++;
        end
        if (ret && trail >= HC) begin
          m_final = 1;
          m_pass = r;
        end else if (m_runcyc == TC) begin
          m_final = 1;
          m_tmo = 1;
        end
      end
    end
    was_full  = (m_fifo.size() == TD);
    was_empty = (m_fifo.size() == 0);
    if (rd && !was_empty) void'(m_fifo.pop_front());
    if (ret) begin
      if (!was_full || (rd && !was_empty)) m_fifo.push_back(p);
      else m_ovf = 1;
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, "_done"}, done, m_final);
    chk({tag, "_pass"}, pass, m_final && m_pass);
    chk({tag, "_timeout"}, timeout, m_tmo);
    chk({tag, "_retired"}, retired, m_retired);
`ifdef CPU_MONITOR_TRACE_EN
    chk({tag, "_empty"}, trace_empty, m_fifo.size() == 0);
    chk({tag, "_ovf"}, trace_ovf, m_ovf);
    if (m_fifo.size() > 0) chk({tag, "_data"}, trace_data, m_fifo[0]);
`else
    chk({tag, "_empty"}, trace_empty, 1'b1);
    chk({tag, "_ovf"}, trace_ovf, 1'b0);
    chk({tag, "_data"}, trace_data, '0);
`endif
  endtask

  task automatic step(input logic [AW-1:0] p, input logic [ST-1:0] s, input logic r,
                      input logic rd, input string tag);
    pc = p; stage = s; result = r; trace_rd = rd;
    model_edge(p, s, r, rd);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  // Hold reset low across one rising edge, checking reset values, then release mid-cycle.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    pc = '0; stage = '0; result = 1'b0; trace_rd = 1'b0;
    model_clear();
    #2;
    compare({tag, "_rst_async"});
    @(posedge clk);
    #1;
    compare({tag, "_rst_held"});
    #3;
    reset = 1'b1;
  endtask

  function automatic logic [ST-1:0] filler();
    logic [ST-1:0] f;
    f = '0;
    f[$urandom_range(0, ST - 2)] = 1'b1;
    return f;
  endfunction

  // Retirements at PCs 0..3 with filler cycles, then HC retirements at PC 5.
  task automatic halt_seq(input logic r, input string tag);
    step(0, '0, 0, 0, {tag, "_idle"});
    for (int i = 0; i < 4; i++) begin
      step(AW'(i), RET, 1'($urandom_range(0, 1)), 0, {tag, "_ret"});
      step(AW'(i), filler(), 1'($urandom_range(0, 1)), 0, {tag, "_fill"});
    end
    for (int k = 0; k < HC; k++) step(5, RET, r, 0, {tag, "_halt"});
    chk({tag, "_final_done"}, done, 1'b1);
    chk({tag, "_final_pass"}, pass, r);
    chk({tag, "_final_timeout"}, timeout, 1'b0);
    chk({tag, "_final_retired"}, retired, 16'd8);
  endtask

  initial begin
    logic [ST-1:0] s;
    int sel;

    do_reset("t0");

    halt_seq(1'b1, "t1");
    step(9, RET, 0, 0, "t1_post");
    chk("t1_post_retired_hold", retired, 16'd8);

    do_reset("t2");
    step(0, '0, 0, 0, "t2_idle");
    step(7, RET, 0, 0, "t2_resume");
    chk("t2_resume_retired", retired, 16'd1);
    chk("t2_resume_done", done, 1'b0);

    do_reset("t3");
    halt_seq(1'b0, "t3");
    for (int i = 0; i < 3; i++) step(0, '0, 0, 1, "t3_pop");

    do_reset("t4");
    step(0, '0, 0, 0, "t4_idle");
    for (int i = 0; i < 3; i++) step(AW'(10 + i), RET, 1, 0, "t4_ret");
    step(20, 5'b00011, 1, 0, "t4_bad");
    chk("t4_bad_done", done, 1'b1);
    chk("t4_bad_pass", pass, 1'b0);
    for (int i = 0; i < 3; i++) step(20, RET, 1, 0, "t4_frozen");
    chk("t4_frozen_retired", retired, 16'd3);

    do_reset("t5");
    step(0, '0, 0, 0, "t5_idle");
    for (int n = 1; n <= 70; n++) begin
      step(AW'(n), RET, 1'($urandom_range(0, 1)), 0, "t5_run");
      if (n == TC - 1) chk("t5_before_timeout", timeout, 1'b0);
      if (n == TC) begin
        chk("t5_timeout", timeout, 1'b1);
        chk("t5_timeout_pass", pass, 1'b0);
      end
    end

    do_reset("t6");
    step(0, '0, 0, 0, "t6_idle");
    for (int i = 0; i < 20; i++) step(AW'(i), RET, 0, 0, "t6_fill");
`ifdef CPU_MONITOR_TRACE_EN
    chk("t6_ovf", trace_ovf, 1'b1);
    for (int i = 0; i < TD; i++) begin
      chk("t6_pop_data", trace_data, AW'(i));
      step(0, '0, 0, 1, "t6_pop");
    end
    chk("t6_empty", trace_empty, 1'b1);
`endif
    step(0, '0, 0, 1, "t6_pop_empty");

    for (int t = 0; t < 3; t++) begin
      do_reset("t7");
      step(0, '0, 0, 0, "t7_idle");
      for (int c = 0; c < 90; c++) begin
        sel = $urandom_range(0, 15);
        if (sel < 6) s = RET;
        else if (sel < 13) s = ($urandom_range(0, 1) == 0) ? '0 : filler();
        else if ($urandom_range(0, 7) == 0) s = 5'b01010;
        else s = RET;
        step(AW'($urandom_range(0, t + 1)), s, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), "t7_rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_debug_monitor.md
CPU_DEBUG_MONITOR -- requirements
Module: cpu_debug_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default `TEST_I_ADDR_WIDTH, width of the observed program counter.
REQ-002 SHALL have parameter STAGES, default `STAGE_COUNT, width of the one-hot pipeline-stage vector.
REQ-003 SHALL have parameter HALT_COUNT, default 4, the number of consecutive retirements at the same PC that marks a halt.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, the watchdog limit in clock cycles.
REQ-005 SHALL have parameter TRACE_DEPTH, default 16 (power of two), the trace FIFO depth.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit; the reset is asynchronous and active-low.
REQ-008 SHALL have port debug_program_counter, input, ADDR_W bits, the CPU's current PC.
REQ-009 SHALL have port debug_pipeline_stage, input, STAGES bits, the CPU's one-hot stage vector.
REQ-010 SHALL have port result, input, 1 bit, the CPU's self-test result flag.
REQ-011 SHALL have port done, output, 1 bit, asserted when a verdict is final.
REQ-012 SHALL have port pass, output, 1 bit, asserted for a verdict of halt with result=1.
REQ-013 SHALL have port timeout, output, 1 bit, asserted when the watchdog expires.
REQ-014 SHALL have port retired, output, 16 bits, the retired-instruction count; it saturates at 0xFFFF.
REQ-015 SHALL have port trace_rd, input, 1 bit, the trace FIFO pop request.
REQ-016 SHALL have ports trace_data (output, ADDR_W bits) and trace_empty (output, 1 bit), the FIFO head and empty flag.
REQ-017 SHALL have port trace_ovf, output, 1 bit, a sticky flag for a retirement dropped because the FIFO was full.

Function
REQ-018 SHALL define a retirement as a cycle in RUN where debug_pipeline_stage[STAGES-1]=1.
REQ-019 SHALL implement the states IDLE, RUN, PASS, FAIL and TIMEOUT.
REQ-020 SHALL leave IDLE for RUN on the first clock edge after reset is released.
REQ-021 SHALL, in RUN, go to FAIL when debug_pipeline_stage is non-zero and not one-hot, with priority over every other transition.
REQ-022 SHALL, in RUN, count consecutive retirements with an unchanged PC; the counter resets to 1 on any PC change at a retirement.
REQ-023 SHALL, when the same-PC counter reaches HALT_COUNT, go to PASS if result=1 on that cycle and to FAIL otherwise.
REQ-024 SHALL increment the watchdog every RUN cycle and go to TIMEOUT when it equals TIMEOUT_CYCLES-1 without a halt.
REQ-025 SHALL give halt priority over timeout when both occur in the same cycle.
REQ-026 SHALL treat PASS, FAIL and TIMEOUT as terminal: they are left only by reset.
REQ-027 SHALL register the outputs so they change one cycle after the causing edge: done=1 in all terminal states, pass=1 only in PASS, timeout=1 only in TIMEOUT.
REQ-028 SHALL increment retired on each retirement in RUN and hold it in all other states.
REQ-029 SHALL push the PC into the trace FIFO on every retirement in RUN.
REQ-030 SHALL drop the push and set trace_ovf when the FIFO is full.
REQ-031 SHALL perform both the push and the pop when trace_rd is asserted on the same cycle as a full-FIFO push, with no overflow.
REQ-032 SHALL ignore trace_rd while trace_empty=1.
REQ-033 SHALL show trace_data as the FIFO head combinationally from storage, valid while trace_empty=0.
REQ-034 SHALL keep the trace FIFO readable in the terminal states.

Reset
REQ-035 SHALL, while reset=0, force the state to IDLE; done, pass, timeout and trace_ovf to 0; retired and all counters to 0; trace_empty to 1; the FIFO pointers to 0.
REQ-036 SHALL, on reset asserted mid-operation, discard any verdict and the FIFO contents.

Configuration
REQ-037 SHALL compile in the trace FIFO logic and REQ-029..034 when the macro CPU_MONITOR_TRACE_EN is defined.
REQ-038 SHALL, when CPU_MONITOR_TRACE_EN is undefined, instantiate no FIFO, tie trace_empty=1, trace_data=0 and trace_ovf=0, ignore trace_rd, and leave all other behaviour unchanged.

Structure
REQ-039 SHALL place the state encodings (3-bit) and the default HALT_COUNT, TIMEOUT_CYCLES and TRACE_DEPTH constants in the shared defines.vh.
REQ-040 SHALL implement the FIFO as one sub-module, trace_fifo, which is synchronous, with parameters width and depth, and with full/empty derived from pointers that carry one extra wrap bit.

Verification
REQ-041 SHALL verify: stage pulses at PCs 0,1,2,3 then 4 retirements at PC=5 with result=1 -> pass=1 and done=1 one cycle after the 4th, retired=8.
REQ-042 SHALL verify: the same sequence with result=0 -> done=1, pass=0, timeout=0.
REQ-043 SHALL verify: TIMEOUT_CYCLES=64 and PC incrementing forever -> timeout=1 on cycle 64 of RUN, pass=0.
REQ-044 SHALL verify: debug_pipeline_stage=2'b11 mid-run -> FAIL next cycle, retired frozen.
REQ-045 SHALL verify: 20 retirements at PCs 0..19 with TRACE_DEPTH=16 and no reads -> trace_ovf=1; 16 pops return PCs 0..15, then trace_empty=1.
REQ-046 SHALL verify: reset=0 asserted for 1 cycle after PASS -> all outputs at their REQ-035 values, then RUN resumes.
